spi_slave_tx: RTL
=================

# spi_slave_tx

SPI mode-0 slave transmitter that returns one 128-bit AES result block to the external SPI master on MISO, MSB first. It is the transmit-side counterpart of the chip's SPI receive path. It sits between the AES core's output register and the pad ring. SCLK and SS_N are sampled in the system clock domain, and all shifting is done on synchronized edges.

## Interface
- NUM_BITS, default 128: number of bits per transfer. It must be ≤255 so that the 8-bit bit counter never wraps.
- clk  input  1  system clock; all state updates on the rising edge.
- n_rst  input  1  asynchronous, active-low reset.
- sclk  input  1  SPI clock from the master, asynchronous to clk, idle low (mode 0).
- ss_n  input  1  SPI slave select from the master, active low, asynchronous to clk.
- tx_data  input  NUM_BITS  block to send; sampled only on an accepted tx_load.
- tx_load  input  1  single-cycle load strobe from the AES core.
- tx_ready  output  1  high in IDLE; tx_load is accepted only while tx_ready is high.
- miso  output  1  serial data to the master.
- miso_oe  output  1  pad output enable; high while synchronized ss_n is low.
- tx_done  output  1  one-clk pulse after all NUM_BITS bits have been sampled by the master.
- tx_error  output  1  one-clk pulse when ss_n deasserts mid-transfer.

## Operation
- Synchronizers:
  - 2-flop synchronizers on sclk and ss_n. Reset values are sclk_sync=0 and ss_sync=1.
  - A third flop on each signal provides edge detection: sclk_rise, sclk_fall, ss_fall, ss_rise.
- Shift register: NUM_BITS wide. miso is always shreg[NUM_BITS-1] in LOADED and SHIFT, and 0 otherwise. Shifting is left by one with 0 fill.
- Bit counter: 8 bits, cleared on entry to SHIFT, incremented on each sclk_rise in SHIFT.
- States:
  - IDLE:
    - tx_ready=1.
    - tx_load=1 loads shreg with tx_data, then -> LOADED.
    - sclk activity is ignored.
  - LOADED:
    - Holds data.
    - ss_fall starts the transfer: -> SHIFT, counter=0.
    - If ss_sync is already low when LOADED is entered, the transfer also starts, on the next clk.
  - SHIFT:
    - sclk_rise increments the counter.
    - If the counter reaches NUM_BITS on that increment -> DONE.
    - Otherwise the next sclk_fall shifts shreg.
    - ss_rise before the count reaches NUM_BITS -> IDLE, tx_error pulse, shreg cleared.
  - DONE:
    - tx_done=1 for exactly one clk, then -> IDLE.
    - No shift occurs after the final rising edge.
- Simultaneous events:
  - When ss_rise and the final sclk_rise occur in the same clk, completion takes priority: tx_done, no tx_error.
  - sclk_rise and sclk_fall cannot coincide, because they are edges of a single synchronized signal.
- Ignored inputs:
  - tx_load outside IDLE is ignored; the data is not captured.
  - ss_n low while in IDLE gives miso_oe=1 and miso=0, with no counting and no pulses.
- Reset:
  - Reset mid-transfer forces IDLE immediately (asynchronous) and clears shreg and the counter.
  - The master sees miso=0 and miso_oe=0.

## Timing
- Reset values: tx_ready=1, miso=0, miso_oe=0, tx_done=0, tx_error=0. State is IDLE, the counter is 0, shreg is 0.
- Edge detection latency: 3 clk from a pin edge to the detected event. miso changes 3–4 clk after a falling SCLK pin edge.
- Master requirements:
  - clk frequency ≥ 8× sclk frequency.
  - ss_n low for ≥4 clk before the first SCLK rising edge, so that MSB is stable on miso.
- Load-to-select latency: tx_load accepted at edge N gives tx_ready=0 and miso=tx_data[NUM_BITS-1] from edge N+1.
- Completion: tx_done is asserted in the clk after the state enters DONE, which is 4 clk after the final SCLK rising pin edge (synchronizer plus state register). tx_ready returns high 1 clk after tx_done.
- Back-to-back transfers: the earliest next tx_load is accepted in the same clk that tx_ready=1 is seen.

## Test plan
- Basic transfer:
  - Stimulus: load 128'h00112233_44556677_8899AABB_CCDDEEFF, then run a model master at clk/8 for 128 SCLK cycles.
  - Required: master captures the identical word; tx_done pulses once for 1 clk; tx_ready returns to 1.
- Abort:
  - Stimulus: load, select, 40 SCLK cycles, then deassert ss_n.
  - Required: tx_error pulses once, no tx_done, tx_ready=1, miso=0.
- Load while busy:
  - Stimulus: during SHIFT, pulse tx_load with 128'hFFFF…FF.
  - Required: the transfer completes with the original data; the next transfer sends all-zeros unless reloaded.
- Reset mid-transfer:
  - Stimulus: after 64 bits, assert n_rst low.
  - Required: outputs take their reset values in the same cycle. A subsequent load and transfer of 128'hA5A5…A5 succeeds.
- Unloaded select:
  - Stimulus: ss_n low and 16 SCLK cycles while in IDLE.
  - Required: miso_oe=1, miso=0 throughout, no tx_done, no tx_error, tx_ready stays 1.
- Back-to-back:
  - Stimulus: two consecutive transfers, 128'h1 then 128'h8000…0, with ss_n held low between them.
  - Required: both words are captured correctly, with two tx_done pulses.

Source files
------------

// File: rtl/spi_slave_tx.sv
// spi_slave_tx: SPI mode-0 slave transmitter for one AES result block.
// SCLK and SS_N are brought into the clk domain through 2-flop synchronizers.
// A third flop on each line gives edge detection. The block is sent MSB first
// on miso: the master samples on the rising SCLK edge, and the block shifts on
// the falling edge.
//
// Handshake (tx_load / tx_ready): a block is accepted on a rising clk edge
// where tx_load and tx_ready are both high. tx_ready is high only in IDLE.
// tx_load while tx_ready is low is dropped, and tx_data is not captured.
module spi_slave_tx #(
    parameter int NUM_BITS = 128
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                sclk,
    input  logic                ss_n,
    input  logic [NUM_BITS-1:0] tx_data,
    input  logic                tx_load,
    output logic                tx_ready,
    output logic                miso,
    output logic                miso_oe,
    output logic                tx_done,
    output logic                tx_error,
    output logic [1:0]          o_dbg_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOADED = 2'd1,
        SHIFT  = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Counter value that marks the final rising edge of a transfer.
    localparam logic [7:0] LP_LAST = 8'(NUM_BITS);

    state_t              r_state;
    state_t              w_next_state;
    logic [NUM_BITS-1:0] r_shreg;
    logic [NUM_BITS-1:0] w_shreg_next;
    logic [7:0]          r_count;
    logic [7:0]          w_count_next;
    logic [7:0]          w_count_inc;
    logic                r_tx_error;
    logic                w_tx_error_next;

    logic r_sclk_s1;
    logic r_sclk_s2;
    logic r_sclk_s3;
    logic r_ss_s1;
    logic r_ss_s2;
    logic r_ss_s3;

    logic w_sclk_rise;
    logic w_sclk_fall;
    logic w_ss_fall;
    logic w_ss_rise;
    logic w_last_rise;

    // Synchronize sclk and ss_n. The third stage is used only for edge detection.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_sclk_s1 <= 1'b0;
            r_sclk_s2 <= 1'b0;
            r_sclk_s3 <= 1'b0;
            r_ss_s1   <= 1'b1;
            r_ss_s2   <= 1'b1;
            r_ss_s3   <= 1'b1;
        end else begin
            r_sclk_s1 <= sclk;
            r_sclk_s2 <= r_sclk_s1;
            r_sclk_s3 <= r_sclk_s2;
            r_ss_s1   <= ss_n;
            r_ss_s2   <= r_ss_s1;
            r_ss_s3   <= r_ss_s2;
        end
    end

    assign w_sclk_rise = r_sclk_s2 & ~r_sclk_s3;
    assign w_sclk_fall = ~r_sclk_s2 & r_sclk_s3;
    assign w_ss_fall   = ~r_ss_s2 & r_ss_s3;
    assign w_ss_rise   = r_ss_s2 & ~r_ss_s3;
    assign w_count_inc = r_count + 8'd1;
    assign w_last_rise = w_sclk_rise && (w_count_inc == LP_LAST);

    // State, shift register, bit counter and error pulse registers.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state    <= IDLE;
            r_shreg    <= '0;
            r_count    <= '0;
            r_tx_error <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_shreg    <= w_shreg_next;
            r_count    <= w_count_next;
            r_tx_error <= w_tx_error_next;
        end
    end

    // Next-state logic. In SHIFT, the final rising edge takes priority over ss
    // deassertion, and ss deassertion takes priority over a falling edge.
    // A falling edge before the first rise is left over from a previous
    // transfer, so it must not shift.
    always_comb begin
        w_next_state    = r_state;
        w_shreg_next    = r_shreg;
        w_count_next    = r_count;
        w_tx_error_next = 1'b0;
        case (r_state)
            IDLE: begin
                if (tx_load) begin
                    w_shreg_next = tx_data;
                    w_next_state = LOADED;
                end
            end
            LOADED: begin
                if (w_ss_fall || !r_ss_s2) begin
                    w_count_next = '0;
                    w_next_state = SHIFT;
                end
            end
            SHIFT: begin
                if (w_last_rise) begin
                    w_count_next = w_count_inc;
                    w_next_state = DONE;
                end else if (w_ss_rise) begin
                    w_shreg_next    = '0;
                    w_count_next    = '0;
                    w_tx_error_next = 1'b1;
                    w_next_state    = IDLE;
                end else if (w_sclk_rise) begin
                    w_count_next = w_count_inc;
                end else if (w_sclk_fall && (r_count != 8'd0)) begin
                    w_shreg_next = {r_shreg[NUM_BITS-2:0], 1'b0};
                end
            end
            DONE: begin
                w_shreg_next = '0;
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    assign tx_ready    = (r_state == IDLE);
    assign tx_done     = (r_state == DONE);
    assign tx_error    = r_tx_error;
    assign miso_oe     = ~r_ss_s2;
    assign miso        = ((r_state == LOADED) || (r_state == SHIFT)) ? r_shreg[NUM_BITS-1] : 1'b0;
    assign o_dbg_state = r_state;

endmodule
